// File: rtl/qdma_master_pkg.sv
// Shared types and defaults for the QBUS DMA bus master.
package qdma_master_pkg;

    localparam int TIMEOUT_DEF = 200;
    localparam int SETUP_DEF   = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_SACK,
        ST_ADDR,
        ST_ASYNC,
        ST_STROBE,
        ST_LATCH,
        ST_RELEASE,
        ST_DONE
    } state_t;

    function automatic logic [7:0] cnt_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/qdma_master.sv
// QBUS DMA master: arbitrates for the bus and runs one DATI/DATO cycle per start pulse.
// Latency: at least 2*SETUP+6 qclk from start to done; STROBE aborts TIMEOUT cycles after entry.
// Backpressure: start is ignored while busy; bus progress waits on RDMGI and RRPLY.
module qdma_master
    import qdma_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int SETUP   = SETUP_DEF
) (
    input  logic        qclk,
    input  logic        init,
    input  logic        start,
    input  logic        wr,
    input  logic [21:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        nxm,
    output logic [15:0] rdata,
    output logic        TDMR,
    input  logic        RDMGI,
    output logic        TDMGO,
    output logic        TSACK,
    input  logic        RSACK,
    output logic        TSYNC,
    output logic        TDIN,
    output logic        TDOUT,
    output logic        TWTBT,
    input  logic        RSYNC,
    input  logic        RRPLY,
    inout  wire  [21:0] ZDAL,
    output logic        DALbe_L,
    output logic        DALtx,
    output logic        DALst
);

    localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
    // STROBE exits two cycles early so RELEASE+DONE land done exactly TIMEOUT after entry.
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 2);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        rrply_s;
    logic        wr_r;
    logic [21:1] addr_r;
    logic [15:0] wdata_r;
    logic        set_nxm, cap_rdata;
    logic        dal_oe, dal_addr;
    logic        unused_bits;

    assign unused_bits = ^{addr[0], ZDAL[21:16]};

    always_ff @(posedge qclk or posedge init) begin
        if (init) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rrply_s <= 1'b0;
            wr_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata   <= '0;
            nxm     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state_nxt != state) ? 8'd0 : cnt_inc(cnt);
            rrply_s <= RRPLY;
            if (state == ST_IDLE && start) begin
                wr_r    <= wr;
                addr_r  <= addr[21:1];
                wdata_r <= wdata;
                nxm     <= 1'b0;
            end
            if (set_nxm) begin
                nxm <= 1'b1;
            end
            if (cap_rdata) begin
                rdata <= ZDAL[15:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        set_nxm   = 1'b0;
        cap_rdata = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        TDMR      = 1'b0;
        TDMGO     = 1'b0;
        TSACK     = 1'b0;
        TSYNC     = 1'b0;
        TDIN      = 1'b0;
        TDOUT     = 1'b0;
        TWTBT     = 1'b0;
        DALst     = 1'b0;
        dal_oe    = 1'b0;
        dal_addr  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy  = 1'b0;
                TDMGO = RDMGI;
                if (start) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                TDMR = 1'b1;
                if (RDMGI && !RSACK && !RSYNC) state_nxt = ST_SACK;
            end
            ST_SACK: begin
                TSACK = 1'b1;
                if (!RDMGI) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                TSACK    = 1'b1;
                dal_oe   = 1'b1;
                dal_addr = 1'b1;
                TWTBT    = wr_r;
                if (cnt == SETUP_LAST) state_nxt = ST_ASYNC;
            end
            ST_ASYNC: begin
                // Address is held one cycle past SYNC for slaves that latch on its edge.
                TSACK    = 1'b1;
                TSYNC    = 1'b1;
                dal_addr = (cnt == 8'd0);
                dal_oe   = dal_addr | wr_r;
                if (cnt == SETUP_LAST) state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                TSACK  = 1'b1;
                TSYNC  = 1'b1;
                TDIN   = ~wr_r;
                TDOUT  = wr_r;
                dal_oe = wr_r;
                if (rrply_s) begin
                    cap_rdata = ~wr_r;
                    DALst     = ~wr_r;
                    state_nxt = ST_LATCH;
                end else if (cnt == TO_LAST) begin
                    set_nxm   = 1'b1;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_LATCH: begin
                TSACK  = 1'b1;
                TSYNC  = 1'b1;
                dal_oe = wr_r;
                if (!rrply_s) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ZDAL    = dal_oe ? (dal_addr ? {addr_r, 1'b0} : {6'b0, wdata_r}) : 'z;
    assign DALbe_L = ~dal_oe;
    assign DALtx   = dal_oe;

endmodule

// File: tb/tb_qdma_master.sv
// Bench for qdma_master: QBUS memory/arbiter responder, vector table, random transfers vs. a memory model.
module tb_qdma_master;

    localparam int TO = 20;
    localparam int SU = 3;

    logic        qclk = 1'b0, init = 1'b1, start = 1'b0, wr = 1'b0;
    logic [21:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        busy, done, nxm;
    logic [15:0] rdata;
    logic        TDMR, TDMGO, TSACK, TSYNC, TDIN, TDOUT, TWTBT;
    logic        RSACK = 1'b0, RSYNC = 1'b0, RRPLY = 1'b0;
    logic        RDMGI;
    wire  [21:0] ZDAL;
    logic        DALbe_L, DALtx, DALst;

    logic        mem_drive = 1'b0;
    logic [15:0] mem_val = '0;
    logic        auto_gnt = 1'b0, man_gnt = 1'b0;
    bit          grant_auto = 1'b1, rep_en = 1'b1;
    int          rep_dly = 0, gnt_dly = 0;

    assign ZDAL  = mem_drive ? {6'b0, mem_val} : 'z;
    assign RDMGI = grant_auto ? auto_gnt : man_gnt;

    qdma_master #(.TIMEOUT(TO), .SETUP(SU)) dut (
        .qclk(qclk), .init(init), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .nxm(nxm), .rdata(rdata),
        .TDMR(TDMR), .RDMGI(RDMGI), .TDMGO(TDMGO), .TSACK(TSACK), .RSACK(RSACK),
        .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .TWTBT(TWTBT),
        .RSYNC(RSYNC), .RRPLY(RRPLY), .ZDAL(ZDAL),
        .DALbe_L(DALbe_L), .DALtx(DALtx), .DALst(DALst)
    );

    initial forever #5 qclk = ~qclk;

    int tests = 0, fails = 0;
    int cyc = 0, st_cyc = 0, strobe_cyc = 0, done_cnt = 0, bus_err = 0;
    logic [21:0] addr_seen = '0;
    logic        twtbt_seen = 1'b0, strobe_q = 1'b0;
    logic [15:0] dout_seen = '0;
    logic [15:0] bus_mem [logic [21:0]];
    logic [15:0] ref_mem [logic [21:0]];

    typedef struct {
        logic        w;
        logic [21:0] a;
        logic [15:0] d;
        bit          pre_en;
        logic [15:0] pre;
        bit          rep;
        logic        exp_nxm;
        logic [15:0] exp_rd;
        logic [21:0] exp_a;
    } vec_t;

    typedef struct {
        bit          ok;
        int          lat, s2d, ndone;
        logic        nx, idle, tw;
        logic [15:0] rd, dout;
        logic [21:0] a_seen;
    } xres_t;

    function automatic logic [15:0] dflt(input logic [21:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] model_read(input logic [21:0] ea);
        return ref_mem.exists(ea) ? ref_mem[ea] : dflt(ea);
    endfunction

    initial forever begin
        @(posedge qclk);
        cyc++;
    end

    // Bus-side memory and grant arbiter
    logic [21:0] baddr = '0;
    logic        sync_q = 1'b0;
    int          rd_wait = 0, gd_wait = 0;
    initial forever begin
        @(posedge qclk);
        #2;
        if (TSYNC && !sync_q) baddr = {ZDAL[21:1], 1'b0};
        sync_q = TSYNC;
        if (TSACK || !TDMR) begin
            auto_gnt = 1'b0;
            gd_wait = 0;
        end else if (gd_wait >= gnt_dly) auto_gnt = 1'b1;
        else gd_wait++;
        if ((TDIN || TDOUT) && !RRPLY && rep_en) begin
            if (rd_wait >= rep_dly) begin
                if (TDIN) begin
                    mem_val = bus_mem.exists(baddr) ? bus_mem[baddr] : dflt(baddr);
                    mem_drive = 1'b1;
                end else bus_mem[baddr] = ZDAL[15:0];
                RRPLY = 1'b1;
                rd_wait = 0;
            end else rd_wait++;
        end else if (!(TDIN || TDOUT)) begin
            RRPLY = 1'b0;
            mem_drive = 1'b0;
            rd_wait = 0;
        end
    end

    initial forever begin
        @(negedge qclk);
        if (done) done_cnt++;
        if (DALtx && !TSYNC) begin
            addr_seen = ZDAL;
            twtbt_seen = TWTBT;
        end
        if (TDOUT) dout_seen = ZDAL[15:0];
        if ((TDIN || TDOUT) && !strobe_q) strobe_cyc = cyc;
        strobe_q = TDIN || TDOUT;
        if ((DALtx && mem_drive) || (DALtx == DALbe_L)) bus_err++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic pulse_start(input logic w, input logic [21:0] a, input logic [15:0] d);
        @(negedge qclk);
        wr = w; addr = a; wdata = d; start = 1'b1;
        st_cyc = cyc;
        @(negedge qclk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output int dcyc, output logic idle,
                             output logic nx, output logic [15:0] rd);
        int n;
        ok = 0; dcyc = 0; idle = 0; nx = 0; rd = 0; n = 0;
        while (!ok && n < TO + 100) begin
            if (done) begin
                ok = 1;
                dcyc = cyc;
                idle = !(TSYNC | TDIN | TDOUT | TSACK | TDMR | DALtx);
                nx = nxm;
                rd = rdata;
            end else begin
                @(negedge qclk);
                n++;
            end
        end
    endtask

    task automatic do_xfer(input logic w, input logic [21:0] a, input logic [15:0] d, output xres_t r);
        int n0, dcyc;
        bit ok;
        logic idle, nx;
        logic [15:0] rd;
        n0 = done_cnt;
        pulse_start(w, a, d);
        wait_done(ok, dcyc, idle, nx, rd);
        r.ok = ok; r.idle = idle; r.nx = nx; r.rd = rd;
        r.lat = dcyc - st_cyc;
        r.s2d = dcyc - strobe_cyc;
        r.a_seen = addr_seen; r.tw = twtbt_seen; r.dout = dout_seen;
        repeat (3) @(negedge qclk);
        r.ndone = done_cnt - n0;
    endtask

    // Checks every transfer against the transaction-level memory model.
    task automatic check_xfer(input string tag, input logic w, input logic [21:0] a,
                              input logic [15:0] d, input bit rep, input xres_t r);
        logic [21:0] ea;
        ea = {a[21:1], 1'b0};
        chk({tag, "_done"}, 32'(r.ok), 32'd1);
        chk({tag, "_ndone"}, 32'(r.ndone), 32'd1);
        chk({tag, "_nxm"}, 32'(r.nx), 32'(!rep));
        chk({tag, "_addr"}, 32'(r.a_seen), 32'(ea));
        chk({tag, "_twtbt"}, 32'(r.tw), 32'(w));
        chk({tag, "_released"}, 32'(r.idle), 32'd1);
        chk({tag, "_latency"}, 32'(r.lat >= 2 * SU + 6), 32'd1);
        if (w) chk({tag, "_dout"}, 32'(r.dout), 32'(d));
        if (!rep) chk({tag, "_timeout"}, 32'(r.s2d), 32'(TO));
        if (!w && rep) chk({tag, "_rdata"}, 32'(r.rd), 32'(model_read(ea)));
        if (w && rep) ref_mem[ea] = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t  tbl [6];
    xres_t r;

    initial begin
        int n0, n;
        bit seen;
        logic w;
        logic [21:0] a;
        logic [15:0] d;
        bit rep;

        tbl[0] = '{1'b0, 22'o1234,  16'h0,    1'b1, 16'o5252, 1'b1, 1'b0, 16'o5252, 22'o1234};
        tbl[1] = '{1'b1, 22'o17776, 16'o1,    1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    22'o17776};
        tbl[2] = '{1'b0, 22'o17777, 16'h0,    1'b0, 16'h0,    1'b1, 1'b0, 16'o1,    22'o17776};
        tbl[3] = '{1'b0, 22'h3FFFFF, 16'h0,   1'b0, 16'h0,    1'b0, 1'b1, 16'h0,    22'h3FFFFE};
        tbl[4] = '{1'b1, 22'o2000,  16'hBEEF, 1'b0, 16'h0,    1'b0, 1'b1, 16'h0,    22'o2000};
        tbl[5] = '{1'b0, 22'o0,     16'h0,    1'b1, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 22'o0};

        // Reset state, with a start pulse that must be ignored under init
        @(negedge qclk);
        start = 1'b1;
        @(negedge qclk);
        start = 1'b0;
        @(negedge qclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_nxm", 32'(nxm), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_tout", 32'({TDMR, TSACK, TSYNC, TDIN, TDOUT, TWTBT}), 32'd0);
        chk("rst_dal", 32'({DALbe_L, DALtx, DALst}), 32'b100);
        init = 1'b0;
        repeat (2) @(negedge qclk);

        // Grant passes straight through while idle and is not absorbed
        grant_auto = 1'b0;
        man_gnt = 1'b1;
        #1 chk("idle_tdmgo_hi", 32'(TDMGO), 32'd1);
        man_gnt = 1'b0;
        #1 chk("idle_tdmgo_lo", 32'(TDMGO), 32'd0);
        @(negedge qclk);
        chk("idle_no_absorb", 32'(busy), 32'd0);

        // Grant arriving in REQ is taken, not passed on
        pulse_start(1'b0, 22'o100, 16'h0);
        chk("req_tdmr", 32'(TDMR), 32'd1);
        man_gnt = 1'b1;
        #1 chk("req_tdmgo", 32'(TDMGO), 32'd0);
        @(negedge qclk);
        chk("req_tsack", 32'({TSACK, TDMR}), 32'b10);
        man_gnt = 1'b0;
        begin
            bit ok; int dc; logic id, nx; logic [15:0] rd;
            wait_done(ok, dc, id, nx, rd);
            chk("req_done", 32'(ok), 32'd1);
            chk("req_rdata", 32'(rd), 32'(model_read(22'o100)));
        end
        grant_auto = 1'b1;
        repeat (2) @(negedge qclk);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            rep_en = tbl[i].rep;
            if (tbl[i].pre_en) begin
                bus_mem[tbl[i].exp_a] = tbl[i].pre;
                ref_mem[tbl[i].exp_a] = tbl[i].pre;
            end
            do_xfer(tbl[i].w, tbl[i].a, tbl[i].d, r);
            chk($sformatf("tbl%0d_nxm", i), 32'(r.nx), 32'(tbl[i].exp_nxm));
            chk($sformatf("tbl%0d_addr", i), 32'(r.a_seen), 32'(tbl[i].exp_a));
            if (!tbl[i].w && tbl[i].rep) chk($sformatf("tbl%0d_rdata", i), 32'(r.rd), 32'(tbl[i].exp_rd));
            check_xfer($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rep, r);
        end
        rep_en = 1'b1;

        // init during STROBE releases the bus at once and yields no done
        rep_en = 1'b0;
        n0 = done_cnt;
        pulse_start(1'b0, 22'o200, 16'h0);
        seen = 0;
        n = 0;
        while (!seen && n < 60) begin
            @(negedge qclk);
            seen = TDIN;
            n++;
        end
        chk("abort_reached_strobe", 32'(seen), 32'd1);
        @(posedge qclk);
        #2 init = 1'b1;
        #1;
        chk("abort_strobes", 32'({TSYNC, TDIN, TSACK, TDMR}), 32'd0);
        chk("abort_dal", 32'({DALtx, DALbe_L}), 32'b01);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge qclk);
        init = 1'b0;
        repeat (TO + 10) @(negedge qclk);
        chk("abort_no_done", 32'(done_cnt - n0), 32'd0);
        rep_en = 1'b1;

        // Starts while busy, including on the done cycle, are ignored
        n0 = done_cnt;
        pulse_start(1'b0, 22'o300, 16'h0);
        repeat (3) @(negedge qclk);
        pulse_start(1'b1, 22'o400, 16'h1234);
        begin
            bit ok; int dc; logic id, nx; logic [15:0] rd;
            wait_done(ok, dc, id, nx, rd);
            wr = 1'b0; addr = 22'o500; start = 1'b1;
            chk("busy_at_done", 32'(busy), 32'd1);
            @(negedge qclk);
            start = 1'b0;
            chk("dbl_idle", 32'({busy, TDMR}), 32'd0);
            chk("dbl_rdata", 32'(rd), 32'(model_read(22'o300)));
        end
        repeat (TO + 20) @(negedge qclk);
        chk("dbl_one_done", 32'(done_cnt - n0), 32'd1);
        chk("dbl_addr", 32'(addr_seen), 32'(22'o300));

        // Randomized transfers against the memory model
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 0) ? 22'($urandom) : 22'(22'h1000 + $urandom_range(0, 15));
            d = 16'($urandom);
            rep = ($urandom_range(0, 7) != 0);
            rep_dly = $urandom_range(0, 5);
            gnt_dly = $urandom_range(0, 3);
            rep_en = rep;
            do_xfer(w, a, d, r);
            check_xfer($sformatf("rnd%0d", i), w, a, d, rep, r);
        end

        chk("bus_drive_rules", 32'(bus_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
